// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock FIFO with occupancy count, threshold flags and sticky
//   overflow/underflow error flags.
//
//   Optional build macro: SYNC_FIFO_FWFT_EN
//     defined   -> first-word-fall-through: r_data shows the head word
//                  whenever the FIFO is non-empty, r_valid = !empty_flag.
//     undefined -> standard mode: r_data is registered on an accepted read
//                  and r_valid pulses for the cycle after that edge.
//
//   Ports
//     clk           rising-edge clock
//     rst           asynchronous active-high reset
//     w_en, w_data  write request and data
//     r_en          read request
//     err_clr       synchronous clear of overflow/underflow
//     r_data        read data
//     r_valid       r_data holds a popped (or head) word
//     full_flag     count == DEPTH
//     empty_flag    count == 0
//     almost_full   count >= AFULL_THRESH
//     almost_empty  count <= AEMPTY_THRESH
//     count         words currently stored
//     overflow      sticky: write attempted while full
//     underflow     sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic [DATA_WIDTH-1:0]      w_data,
    input  logic                       r_en,
    input  logic                       err_clr,
    output logic [DATA_WIDTH-1:0]      r_data,
    output logic                       r_valid,
    output logic                       full_flag,
    output logic                       empty_flag,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW + 1)'(AFULL_THRESH);
    localparam logic [AW:0] AE_CNT   = (AW + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one wrap bit above the address bits.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic wr_acc;
    logic rd_acc;

    // All status flags decode from the registered count.
    assign full_flag    = (count == FULL_CNT);
    assign empty_flag   = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign wr_acc = w_en && !full_flag;
    assign rd_acc = r_en && !empty_flag;

    // Storage is intentionally not reset; the read path never exposes an
    // unwritten location.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // err_clr wins over a same-cycle error event.
            if (err_clr) begin
                overflow <= 1'b0;
            end else if (w_en && full_flag) begin
                overflow <= 1'b1;
            end

            if (err_clr) begin
                underflow <= 1'b0;
            end else if (r_en && empty_flag) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented combinationally; zero while empty.
    assign r_data  = empty_flag ? '0 : mem[rd_ptr[AW-1:0]];
    assign r_valid = !empty_flag;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_acc;
            if (rd_acc) begin
                r_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int DW = 16;
    localparam int D  = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic          r_en;
    logic          err_clr;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          full_flag;
    logic          empty_flag;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH   (DW),
        .DEPTH        (D),
        .AFULL_THRESH (AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .w_data      (w_data),
        .r_en        (r_en),
        .err_clr     (err_clr),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .full_flag   (full_flag),
        .empty_flag  (empty_flag),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of stored words plus sticky flags.
    logic [DW-1:0] m_q[$];
    logic          m_ovf;
    logic          m_unf;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        logic          c;
        int            ecount;
        logic          eempty;
        logic          eunf;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic check_model(input string tag);
        int n = m_q.size();
        logic [DW-1:0] er;
        logic ev;
`ifdef SYNC_FIFO_FWFT_EN
        ev = (n > 0);
        er = (n > 0) ? m_q[0] : '0;
`else
        ev = m_rvalid;
        er = m_rdata;
`endif
        chk({tag, ":count"},        count,        n);
        chk({tag, ":full"},         full_flag,    n == D);
        chk({tag, ":empty"},        empty_flag,   n == 0);
        chk({tag, ":almost_full"},  almost_full,  n >= AF);
        chk({tag, ":almost_empty"}, almost_empty, n <= AE);
        chk({tag, ":overflow"},     overflow,     m_ovf);
        chk({tag, ":underflow"},    underflow,    m_unf);
        chk({tag, ":r_valid"},      r_valid,      ev);
        chk({tag, ":r_data"},       r_data,       er);
    endtask

    // One clock of stimulus; the model advances from the pre-edge occupancy.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        int n;
        w_en = w; w_data = d; r_en = r; err_clr = c;
        @(posedge clk);
        n = m_q.size();
        m_rvalid = 1'b0;
        if (r && n > 0) begin
            m_rdata  = m_q.pop_front();
            m_rvalid = 1'b1;
        end
        if (w && n < D) m_q.push_back(d);
        if (c) m_ovf = 1'b0; else if (w && n == D) m_ovf = 1'b1;
        if (c) m_unf = 1'b0; else if (r && n == 0) m_unf = 1'b1;
        #1;
        w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
        check_model("step");
    endtask

    task automatic drain();
        while (m_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ":count"},        count,        0);
        chk({tag, ":empty"},        empty_flag,   1);
        chk({tag, ":full"},         full_flag,    0);
        chk({tag, ":almost_empty"}, almost_empty, 1);
        chk({tag, ":almost_full"},  almost_full,  0);
        chk({tag, ":overflow"},     overflow,     0);
        chk({tag, ":underflow"},    underflow,    0);
        chk({tag, ":r_valid"},      r_valid,      0);
        chk({tag, ":r_data"},       r_data,       0);
    endtask

    initial begin
        rst = 1'b0; w_en = 1'b0; w_data = '0; r_en = 1'b0; err_clr = 1'b0;
        model_reset();

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #2 chk_reset_outputs("por");
        @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Table-driven vectors starting from empty.
        tbl[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 16'h0022, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h0033, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
            chk("tbl:count",     count,      tbl[i].ecount);
            chk("tbl:empty",     empty_flag, tbl[i].eempty);
            chk("tbl:underflow", underflow,  tbl[i].eunf);
        end

        // Fill to full, then read back in order.
        for (int i = 1; i <= D; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("fill:full",  full_flag, 1);
        chk("fill:count", count,     16);
        for (int i = 1; i <= D; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("order:head", r_data, i);
            step(1'b0, '0, 1'b1, 1'b0);
`else
            step(1'b0, '0, 1'b1, 1'b0);
            chk("order:r_data",  r_data,  i);
            chk("order:r_valid", r_valid, 1);
`endif
        end
        chk("order:empty", empty_flag, 1);

        // Overflow while full, err_clr priority, and clear.
        for (int i = 0; i < D; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("ovf:count", count,    16);
        chk("ovf:set",   overflow, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf:clr", overflow, 0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b1);
        chk("ovf:clr_priority", overflow, 0);
        drain();

        // Steady occupancy of 8 across pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0);
            chk("wrap:count", count, 8);
            chk("wrap:af",    almost_full,  0);
            chk("wrap:ae",    almost_empty, 0);
        end
        drain();

        // Threshold sweep.
        for (int i = 1; i <= AF; i++) begin
            step(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
            if (i == 2)  chk("thr:ae_at2",  almost_empty, 1);
            if (i == 3)  chk("thr:ae_at3",  almost_empty, 0);
            if (i == 13) chk("thr:af_at13", almost_full,  0);
            if (i == 14) chk("thr:af_at14", almost_full,  1);
        end
        drain();

        // Randomized traffic: write-biased phase then read-biased phase.
        for (int i = 0; i < 400; i++) begin
            int wb = (i < 200) ? 70 : 35;
            step($urandom_range(0, 99) < wb, 16'($urandom),
                 $urandom_range(0, 99) < (100 - wb), $urandom_range(0, 99) < 5);
        end

        // Reset in the middle of a cycle with data stored.
        drain();
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0500 + 16'(i), 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step(1'b1, 16'h00AA, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("postrst:head", r_data, 16'h00AA);
        step(1'b0, '0, 1'b1, 1'b0);
`else
        step(1'b0, '0, 1'b1, 1'b0);
        chk("postrst:r_data", r_data, 16'h00AA);
`endif
        chk("postrst:empty", empty_flag, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
